alu_serial_seq: RTL

Bit-serial ALU sequencer that evaluates the team's eight-function ALU table over a WIDTH-bit operand pair using a single bit-slice datapath, one bit per clock, LSB first. The block sits between the instruction control unit and the register file write-back path. It is used where area matters more than latency. It accepts one operation per start/done handshake and returns a registered result, carry-out and zero flag.

---
 rtl/alu_serial_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial eight-function ALU: one bit-slice evaluated per clock, LSB first.
// Accepts one operation per start/done handshake; result/cout/zero are registered.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic [2:0]         op_r;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               sum_bit, carry_nx;
  logic [WIDTH-1:0]   word;

  // Returns {carry_out, sum} for one bit; carry only evolves for the add/sub rows.
  function automatic logic [1:0] alu_slice(input logic [2:0] f, input logic x,
                                           input logic y, input logic c);
    logic yy;
    yy = f[0] ? ~y : y;
    case (f[2:1])
      2'b00:   alu_slice = {(x & yy) | (x & c) | (yy & c), x ^ yy ^ c};
      2'b01:   alu_slice = {c, x | yy};
      2'b10:   alu_slice = {c, x & yy};
      default: alu_slice = {c, f[0] ? ~y : ~x};
    endcase
  endfunction

  always_comb begin
    {carry_nx, sum_bit} = alu_slice(op_r, a_sr[0], b_sr[0], carry);
    word     = {sum_bit, res_sr[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          res_sr <= word;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_nx;
          cnt    <= cnt + 1'b1;
          // Final slice: publish the assembled word alongside the completion pulse.
          if (last_bit) begin
            result <= word;
            cout   <= carry_nx;
            zero   <= (word == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation (DONE gives back-to-back).
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op_r  <= op;
            carry <= op[0];
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule
